// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA frame-buffer bus controller: register offsets,
// CTRL/STATUS bit positions and the fill-engine state encoding.
package vga_fb_pkg;

    localparam logic [7:0] OFS_COLOUR0     = 8'h00;
    localparam logic [7:0] OFS_COLOUR_LAST = 8'h03;
    localparam logic [7:0] OFS_ADDR_HI     = 8'h04;
    localparam logic [7:0] OFS_ADDR_LO     = 8'h05;
    localparam logic [7:0] OFS_DATA        = 8'h06;
    localparam logic [7:0] OFS_CTRL        = 8'h07;
    localparam logic [7:0] OFS_STATUS      = 8'h08;
    localparam logic [7:0] OFS_FILL_LEN_HI = 8'h09;
    localparam logic [7:0] OFS_FILL_LEN_LO = 8'h0A;

    localparam int CTRL_AUTOINC_BIT    = 0;
    localparam int CTRL_FILL_START_BIT = 1;
    localparam int STATUS_BUSY_BIT     = 0;
    localparam int STATUS_OVERRUN_BIT  = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Registers the fill engine depends on; writing them mid-fill is refused.
    function automatic logic fill_locked(input logic [7:0] ofs, input logic [7:0] wdata);
        return (ofs == OFS_ADDR_HI) || (ofs == OFS_ADDR_LO) || (ofs == OFS_DATA) ||
               (ofs == OFS_FILL_LEN_HI) || (ofs == OFS_FILL_LEN_LO) ||
               ((ofs == OFS_CTRL) && wdata[CTRL_FILL_START_BIT]);
    endfunction

endpackage

// File: rtl/vga_fb_bus_ctrl_if.sv
// Frame-buffer port A: registered address/data/write-enable out, RAM read data back.
interface vga_fb_bus_ctrl_if #(
    parameter int FB_ADDR_W = 15
);
    logic [FB_ADDR_W-1:0] FB_A_ADDR;
    logic [7:0]           FB_A_DATA_OUT;
    logic                 FB_A_WE;
    logic [7:0]           FB_A_DATA_IN;

    modport master (
        output FB_A_ADDR,
        output FB_A_DATA_OUT,
        output FB_A_WE,
        input  FB_A_DATA_IN
    );

    modport slave (
        input  FB_A_ADDR,
        input  FB_A_DATA_OUT,
        input  FB_A_WE,
        output FB_A_DATA_IN
    );
endinterface

// File: rtl/vga_fb_fill_fsm.sv
// Block-fill engine: once started, writes one byte per cycle at consecutive
// (wrapping) addresses until the latched length is exhausted.
module vga_fb_fill_fsm
    import vga_fb_pkg::*;
#(
    parameter int FB_ADDR_W = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FB_ADDR_W-1:0] start_addr,
    input  logic [7:0]           value,
    input  logic [15:0]          length,
    output logic                 we,
    output logic [FB_ADDR_W-1:0] addr,
    output logic [7:0]           data,
    output logic                 busy
);

    fill_state_t          state_reg, state_next;
    logic [15:0]          count_reg, count_next;
    logic [FB_ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]           value_reg, value_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
            value_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            addr_reg  <= addr_next;
            value_reg <= value_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        addr_next  = addr_reg;
        value_next = value_reg;
        unique case (state_reg)
            IDLE: begin
                if (start && (length != 16'h0000)) begin
                    state_next = FILL;
                    count_next = length;
                    addr_next  = start_addr;
                    value_next = value;
                end
            end
            FILL: begin
                addr_next  = addr_reg + FB_ADDR_W'(1);
                count_next = count_reg - 16'h0001;
                // The write issued with one byte left is the last one.
                if (count_reg == 16'h0001) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come straight from state registers, so port A stays glitch-free.
    assign busy = (state_reg == FILL);
    assign we   = busy;
    assign addr = addr_reg;
    assign data = value_reg;

endmodule

// File: rtl/vga_fb_bus_ctrl.sv
// CPU-bus register block for the VGA frame buffer: palette, pointer/data
// access to port A with optional auto-increment, and a hardware block fill.
module vga_fb_bus_ctrl
    import vga_fb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hB0,
    parameter int         NUM_COLOURS  = 2,
    parameter int         FB_ADDR_W    = 15,
    parameter logic [7:0] COLOUR0_INIT = 8'hAD,
    parameter logic [7:0] COLOUR_INIT  = 8'h00
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [7:0]               BUS_ADDR,
    inout  wire  [7:0]               BUS_DATA,
    input  logic                     BUS_WE,
    vga_fb_bus_ctrl_if.master        fb,
    output logic [8*NUM_COLOURS-1:0] CONFIG_COLOURS,
    output logic                     FILL_BUSY
);

    logic [7:0] ofs;
    logic       in_window;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] wdata;
    logic       blocked_wr;
    logic       reg_wr;
    logic       data_wr;
    logic       fill_start;

    logic [FB_ADDR_W-1:0] ptr_reg, ptr_next;
    logic [15:0]          ptr_wide;
    logic                 autoinc_reg, autoinc_next;
    logic                 overrun_reg, overrun_next;
    logic [15:0]          fill_len_reg, fill_len_next;
    logic [7:0]           shadow_reg;

    logic                 wr_we_reg;
    logic [FB_ADDR_W-1:0] wr_addr_reg;
    logic [7:0]           wr_data_reg;
    logic                 rd_oe_reg;
    logic [7:0]           rd_data_reg;
    logic [7:0]           rd_value;
    logic [31:0]          colour_pad;

    logic                 fill_we;
    logic                 fill_busy;
    logic [FB_ADDR_W-1:0] fill_addr;
    logic [7:0]           fill_data;

    // Subtracting the base lets an unsigned compare cover the whole window.
    assign ofs       = BUS_ADDR - BASE_ADDR;
    assign in_window = (ofs <= OFS_FILL_LEN_LO);
    assign bus_wr    = in_window && BUS_WE;
    assign bus_rd    = in_window && !BUS_WE;
    assign wdata     = BUS_DATA;

    assign blocked_wr = bus_wr && fill_busy && fill_locked(ofs, wdata);
    assign reg_wr     = bus_wr && !blocked_wr;
    assign data_wr    = reg_wr && (ofs == OFS_DATA);
    assign fill_start = reg_wr && (ofs == OFS_CTRL) && wdata[CTRL_FILL_START_BIT] &&
                        (fill_len_reg != 16'h0000);

    assign ptr_wide = 16'(ptr_reg);

    always_comb begin
        ptr_next      = ptr_reg;
        autoinc_next  = autoinc_reg;
        fill_len_next = fill_len_reg;
        overrun_next  = overrun_reg;
        if (bus_rd && (ofs == OFS_STATUS)) begin
            overrun_next = 1'b0;
        end
        if (blocked_wr) begin
            overrun_next = 1'b1;
        end
        if (reg_wr) begin
            case (ofs)
                OFS_ADDR_HI:     ptr_next = FB_ADDR_W'({wdata, ptr_wide[7:0]});
                OFS_ADDR_LO:     ptr_next = FB_ADDR_W'({ptr_wide[15:8], wdata});
                OFS_DATA: begin
                    if (autoinc_reg) begin
                        ptr_next = ptr_reg + FB_ADDR_W'(1);
                    end
                end
                OFS_CTRL: begin
                    autoinc_next = wdata[CTRL_AUTOINC_BIT];
                    // Pointer jumps to the end of the block when the fill is accepted.
                    if (fill_start) begin
                        ptr_next = ptr_reg + FB_ADDR_W'(fill_len_reg);
                    end
                end
                OFS_FILL_LEN_HI: fill_len_next[15:8] = wdata;
                OFS_FILL_LEN_LO: fill_len_next[7:0]  = wdata;
                default: ;
            endcase
        end
    end

    assign colour_pad = 32'(CONFIG_COLOURS);

    always_comb begin
        rd_value = 8'h00;
        if (ofs <= OFS_COLOUR_LAST) begin
            rd_value = colour_pad[{ofs[1:0], 3'b000} +: 8];
        end else begin
            case (ofs)
                OFS_ADDR_HI:     rd_value = ptr_wide[15:8];
                OFS_ADDR_LO:     rd_value = ptr_wide[7:0];
                OFS_DATA:        rd_value = fb.FB_A_DATA_IN;
                OFS_CTRL:        rd_value[CTRL_AUTOINC_BIT] = autoinc_reg;
                OFS_STATUS: begin
                    rd_value[STATUS_BUSY_BIT]    = fill_busy;
                    rd_value[STATUS_OVERRUN_BIT] = overrun_reg;
                end
                OFS_FILL_LEN_HI: rd_value = fill_len_reg[15:8];
                OFS_FILL_LEN_LO: rd_value = fill_len_reg[7:0];
                default:         rd_value = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_reg      <= '0;
            autoinc_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            fill_len_reg <= '0;
            shadow_reg   <= '0;
            wr_we_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            rd_oe_reg    <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            autoinc_reg  <= autoinc_next;
            overrun_reg  <= overrun_next;
            fill_len_reg <= fill_len_next;
            wr_we_reg    <= data_wr;
            // Port A follows the pointer when idle so DATA reads see RAM at the pointer.
            wr_addr_reg  <= ptr_reg;
            if (data_wr) begin
                shadow_reg  <= wdata;
                wr_data_reg <= wdata;
            end
            rd_oe_reg   <= bus_rd;
            rd_data_reg <= rd_value;
        end
    end

    for (genvar gi = 0; gi < NUM_COLOURS; gi++) begin : g_colour
        localparam logic [7:0] RST_VAL = (gi == 0) ? COLOUR0_INIT : COLOUR_INIT;
        logic [7:0] colour_reg;

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                colour_reg <= RST_VAL;
            end else if (bus_wr && (ofs == OFS_COLOUR0 + 8'(gi))) begin
                colour_reg <= wdata;
            end
        end

        assign CONFIG_COLOURS[8*gi +: 8] = colour_reg;
    end

    vga_fb_fill_fsm #(
        .FB_ADDR_W (FB_ADDR_W)
    ) u_fill (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .start      (fill_start),
        .start_addr (ptr_reg),
        .value      (shadow_reg),
        .length     (fill_len_reg),
        .we         (fill_we),
        .addr       (fill_addr),
        .data       (fill_data),
        .busy       (fill_busy)
    );

    assign fb.FB_A_WE       = fill_we || wr_we_reg;
    assign fb.FB_A_ADDR     = fill_busy ? fill_addr : wr_addr_reg;
    assign fb.FB_A_DATA_OUT = fill_busy ? fill_data : wr_data_reg;

    assign FILL_BUSY = fill_busy;
    assign BUS_DATA  = rd_oe_reg ? rd_data_reg : 8'hzz;

endmodule

// File: tb/tb_vga_fb_bus_ctrl.sv
// Directed bench for vga_fb_bus_ctrl: bus reads and port-A write pulses are
// checked against scoreboard queues filled as the stimulus is driven.
module tb_vga_fb_bus_ctrl;

    localparam logic [7:0] BASE = 8'hB0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       drive_en;
    logic [7:0] drive_val;
    wire  [7:0] bus_data;
    logic [15:0] config_colours;
    logic        fill_busy;

    always #10 clk = ~clk;

    assign bus_data = drive_en ? drive_val : 8'hzz;

    vga_fb_bus_ctrl_if #(.FB_ADDR_W(15)) fb_if ();

    vga_fb_bus_ctrl dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .BUS_ADDR       (bus_addr),
        .BUS_DATA       (bus_data),
        .BUS_WE         (bus_we),
        .fb             (fb_if),
        .CONFIG_COLOURS (config_colours),
        .FILL_BUSY      (fill_busy)
    );

    // Frame-buffer RAM model with one cycle of read latency.
    logic [7:0] mem [0:32767];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (fb_if.FB_A_WE === 1'b1) mem[fb_if.FB_A_ADDR] <= fb_if.FB_A_DATA_OUT;
        ram_q <= mem[fb_if.FB_A_ADDR];
    end
    assign fb_if.FB_A_DATA_IN = ram_q;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } rd_exp_t;

    typedef struct {
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Monitor: reads answer one cycle after the address; every WE pulse pops the write queue.
    always @(posedge clk) begin
        logic [7:0] o;
        logic       rd_now;
        rd_exp_t    re;
        wr_exp_t    we_e;
        o      = bus_addr - BASE;
        rd_now = (rst_n === 1'b1) && (bus_we === 1'b0) && (o <= 8'h0A);
        #1;
        if (rd_now && rd_q.size() > 0) begin
            re = rd_q.pop_front();
            check(re.tag, 32'(bus_data), 32'(re.val));
        end
        if (fb_if.FB_A_WE === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("spurious_we", 32'(fb_if.FB_A_WE), 32'h0);
            end else begin
                we_e = wr_q.pop_front();
                check("we_addr", 32'(fb_if.FB_A_ADDR), 32'(we_e.addr));
                check("we_data", 32'(fb_if.FB_A_DATA_OUT), 32'(we_e.data));
            end
        end
    end

    task automatic idle();
        bus_addr = 8'h00;
        bus_we   = 1'b0;
        drive_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [7:0] val);
        bus_addr  = BASE + ofs;
        bus_we    = 1'b1;
        drive_val = val;
        drive_en  = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [7:0] ofs, input logic [7:0] exp, input string tag);
        rd_exp_t e;
        e.val = exp;
        e.tag = tag;
        rd_q.push_back(e);
        bus_addr = BASE + ofs;
        bus_we   = 1'b0;
        drive_en = 1'b0;
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic expect_we(input logic [14:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic set_ptr(input logic [14:0] p);
        wr(8'h04, {1'b0, p[14:8]});
        wr(8'h05, p[7:0]);
    endtask

    task automatic wait_fill(input string tag, output int busy_cycles);
        int i;
        busy_cycles = 0;
        i = 0;
        while (fill_busy === 1'b1 && i < 64) begin
            busy_cycles++;
            i++;
            @(negedge clk);
        end
        check(tag, 32'(fill_busy), 32'h0);
    endtask

    initial begin
        int nb;
        idle();
        drive_val = 8'h00;
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_colours", 32'(config_colours), 32'h00AD);
        check("reset_we", 32'(fb_if.FB_A_WE), 32'h0);
        check("reset_busy", 32'(fill_busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        rd(8'h08, 8'h00, "status_reset");
        rd(8'h07, 8'h00, "ctrl_reset");
        rd(8'h00, 8'hAD, "colour0_reset");
        rd(8'h01, 8'h00, "colour1_reset");

        // Palette
        wr(8'h01, 8'h3C);
        rd(8'h01, 8'h3C, "colour1_rw");
        rd(8'h03, 8'h00, "colour3_absent");
        wr(8'h03, 8'h5A);
        rd(8'h03, 8'h00, "colour3_wr_ignored");
        check("colours_out", 32'(config_colours), 32'h3CAD);

        // Auto-increment with pointer wrap
        set_ptr(15'h7FFF);
        wr(8'h07, 8'h01);
        rd(8'h07, 8'h01, "ctrl_autoinc");
        rd(8'h04, 8'h7F, "addr_hi");
        expect_we(15'h7FFF, 8'h11);
        wr(8'h06, 8'h11);
        expect_we(15'h0000, 8'h22);
        wr(8'h06, 8'h22);
        rd(8'h04, 8'h00, "ptr_hi_wrap");
        rd(8'h05, 8'h01, "ptr_lo_wrap");
        set_ptr(15'h7FFF);
        repeat (2) @(negedge clk);
        rd(8'h06, 8'h11, "data_rd_7fff");
        rd(8'h05, 8'hFF, "ptr_no_rd_inc");

        // Block fill of 4 bytes
        wr(8'h07, 8'h00);
        set_ptr(15'h0100);
        expect_we(15'h0100, 8'h55);
        wr(8'h06, 8'h55);
        wr(8'h09, 8'h00);
        wr(8'h0A, 8'h04);
        for (int i = 0; i < 4; i++) expect_we(15'h0100 + 15'(i), 8'h55);
        wr(8'h07, 8'h02);
        wait_fill("fill1_done", nb);
        check("fill1_busy_cycles", 32'(nb), 32'd4);
        rd(8'h04, 8'h01, "fill1_ptr_hi");
        rd(8'h05, 8'h04, "fill1_ptr_lo");
        rd(8'h08, 8'h00, "status_idle");
        rd(8'h0A, 8'h04, "fill_len_lo");
        set_ptr(15'h0103);
        repeat (2) @(negedge clk);
        rd(8'h06, 8'h55, "data_rd_fill");

        // DATA write during a fill is dropped and flags overrun
        wr(8'h0A, 8'h08);
        for (int i = 0; i < 8; i++) expect_we(15'h0103 + 15'(i), 8'h55);
        wr(8'h07, 8'h02);
        wr(8'h06, 8'h77);
        rd(8'h08, 8'h03, "status_overrun");
        wait_fill("fill2_done", nb);
        rd(8'h08, 8'h00, "status_cleared");
        rd(8'h05, 8'h0B, "fill2_ptr_lo");

        // Zero-length fill is a no-op
        wr(8'h0A, 8'h00);
        wr(8'h07, 8'h02);
        nb = 0;
        repeat (4) begin
            if (fill_busy === 1'b1) nb++;
            @(negedge clk);
        end
        check("zero_len_busy", 32'(nb), 32'd0);
        rd(8'h08, 8'h00, "zero_len_status");

        // Reset asserted in the second fill cycle
        wr(8'h0A, 8'h06);
        expect_we(15'h010B, 8'h55);
        expect_we(15'h010C, 8'h55);
        wr(8'h07, 8'h02);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(fb_if.FB_A_WE), 32'h0);
        check("abort_busy", 32'(fill_busy), 32'h0);
        @(negedge clk);
        check("abort_colours", 32'(config_colours), 32'h00AD);
        rst_n = 1'b1;
        @(negedge clk);
        nb = 0;
        repeat (3) begin
            if (fill_busy === 1'b1) nb++;
            @(negedge clk);
        end
        check("post_abort_busy", 32'(nb), 32'd0);
        rd(8'h08, 8'h00, "post_abort_status");
        rd(8'h05, 8'h00, "post_abort_ptr");
        expect_we(15'h0000, 8'h99);
        wr(8'h06, 8'h99);
        repeat (3) @(negedge clk);

        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
